// File: rtl/if_stage_pkg.sv
// Shared widths, reset PC and bus layouts for the instruction-fetch stage.
package if_stage_pkg;

  localparam int IF_TO_ID_BUS_WIDTH = 64;
  localparam int ID_TO_IF_BUS_WIDTH = 34;
  localparam logic [31:0] RESET_PC  = 32'h1c000000;

  typedef struct packed {
    logic        br_taken;
    logic [31:0] br_target;
    logic        br_cancle;
  } id_to_if_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } if_to_id_t;

endpackage

// File: rtl/if_stage.sv
// Instruction fetch: next-PC selection, inst SRAM request, IF pipeline register
// and a one-entry buffer that keeps returned SRAM data alive across ID stalls.
module if_stage
  import if_stage_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ID_TO_IF_BUS_WIDTH-1:0] id_to_if_bus,
  input  logic                          id_allow_in,
  output logic                          if_to_id_valid,
  output logic [IF_TO_ID_BUS_WIDTH-1:0] if_to_id_bus,
  output logic                          inst_sram_en,
  output logic [3:0]                    inst_sram_we,
  output logic [31:0]                   inst_sram_addr,
  output logic [31:0]                   inst_sram_wdata,
  input  logic [31:0]                   inst_sram_rdata
);

  id_to_if_t   w_id_bus;
  if_to_id_t   w_out_bus;
  logic        w_to_if_valid;
  logic        w_if_ready_go;
  logic        w_if_allow_in;
  logic [31:0] w_seq_pc;
  logic [31:0] w_nextpc;
  logic        w_unused_br_taken;

  logic        r_if_valid;
  logic [31:0] r_if_pc;
  logic        r_buf_valid;
  logic [31:0] r_inst_buf;

  assign w_id_bus = id_to_if_t'(id_to_if_bus);
  // br_taken alone may carry a stale target from a stalled branch; only br_cancle redirects.
  assign w_unused_br_taken = w_id_bus.br_taken;

  assign w_to_if_valid = ~reset;
  assign w_if_ready_go = 1'b1;
  assign w_seq_pc      = r_if_pc + 32'd4;
  assign w_nextpc      = w_id_bus.br_cancle ? w_id_bus.br_target : w_seq_pc;
  assign w_if_allow_in = ~r_if_valid | (w_if_ready_go & id_allow_in) | w_id_bus.br_cancle;

  assign inst_sram_en    = w_to_if_valid & w_if_allow_in;
  assign inst_sram_we    = 4'b0000;
  assign inst_sram_addr  = w_nextpc;
  assign inst_sram_wdata = 32'b0;

  assign if_to_id_valid = r_if_valid & w_if_ready_go;
  assign w_out_bus.inst = r_buf_valid ? r_inst_buf : inst_sram_rdata;
  assign w_out_bus.pc   = r_if_pc;
  assign if_to_id_bus   = w_out_bus;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_if_valid <= 1'b0;
      r_if_pc    <= RESET_PC - 32'd4;
    end else if (w_if_allow_in) begin
      r_if_valid <= w_to_if_valid;
      r_if_pc    <= w_nextpc;
    end
  end

  // SRAM data is only valid the cycle after the request, so hold it while ID stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf_valid <= 1'b0;
      r_inst_buf  <= 32'b0;
    end else if (id_allow_in || w_id_bus.br_cancle) begin
      r_buf_valid <= 1'b0;
    end else if (r_if_valid && !r_buf_valid) begin
      r_buf_valid <= 1'b1;
      r_inst_buf  <= inst_sram_rdata;
    end
  end

endmodule
